// File: rtl/instr_encoder.sv
// Instruction encoder: turns instruction descriptors into 32-bit MIPS words,
// queues them in a small FIFO and writes them sequentially into instruction
// memory through a request/acknowledge port.
//
// Handshake semantics (both sides):
//   - Input side: a descriptor transfers on a rising edge where
//     in_valid & in_ready. in_ready never looks at in_valid or at a pop
//     happening in the same cycle, so a full FIFO stays not-ready even
//     while the head is being written out.
//   - IM side: im_we/im_addr/im_wdata are held stable from the first cycle
//     of a write until the edge where im_ack is high; that edge retires the
//     word. im_ack outside a write is ignored.
module instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_kind,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [25:0] in_imm,
  input  logic        in_last,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  input  logic        im_ack,
  output logic        done,
  output logic        err,
  output logic [10:0] count,
  output logic [1:0]  dbg_state
);

  localparam int          AW    = $clog2(DEPTH);
  localparam logic [10:0] MAX_W = 11'(MAX_WORDS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  // FIFO entry: {last, word}
  logic [32:0]   r_mem [DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic          r_live;
  logic [10:0]   r_accepted;
  logic [10:0]   r_count;
  logic [31:0]   r_addr;
  logic          r_err;

  logic [31:0]   w_word;
  logic          w_illegal;
  logic          w_full;
  logic          w_empty;
  logic          w_empty_after_pop;
  logic          w_at_limit;
  logic          w_last_slot;
  logic          w_last;
  logic          w_push;
  logic          w_pop;
  logic [32:0]   w_head;
  logic [AW:0]   w_rptr_inc;

  // Combinational encoding of the presented descriptor
  always_comb begin
    w_word    = 32'h0000_0000;
    w_illegal = 1'b0;
    case (in_kind)
      5'd0:  w_word = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h20}; // add
      5'd1:  w_word = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h21}; // addu
      5'd2:  w_word = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h22}; // sub
      5'd3:  w_word = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h23}; // subu
      5'd4:  w_word = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h24}; // and
      5'd5:  w_word = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h25}; // or
      5'd6:  w_word = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h2A}; // slt
      5'd7:  w_word = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h2B}; // sltu
      5'd8:  w_word = {6'h00, in_rs, 15'h0000, 6'h08};            // jr
      5'd9:  w_word = {6'h08, in_rs, in_rt, in_imm[15:0]};        // addi
      5'd10: w_word = {6'h09, in_rs, in_rt, in_imm[15:0]};        // addiu
      5'd11: w_word = {6'h0C, in_rs, in_rt, in_imm[15:0]};        // andi
      5'd12: w_word = {6'h0D, in_rs, in_rt, in_imm[15:0]};        // ori
      5'd13: w_word = {6'h0F, 5'h00, in_rt, in_imm[15:0]};        // lui
      5'd14: w_word = {6'h23, in_rs, in_rt, in_imm[15:0]};        // lw
      5'd15: w_word = {6'h21, in_rs, in_rt, in_imm[15:0]};        // lh
      5'd16: w_word = {6'h20, in_rs, in_rt, in_imm[15:0]};        // lb
      5'd17: w_word = {6'h2B, in_rs, in_rt, in_imm[15:0]};        // sw
      5'd18: w_word = {6'h29, in_rs, in_rt, in_imm[15:0]};        // sh
      5'd19: w_word = {6'h28, in_rs, in_rt, in_imm[15:0]};        // sb
      5'd20: w_word = {6'h04, in_rs, in_rt, in_imm[15:0]};        // beq
      5'd21: w_word = {6'h05, in_rs, in_rt, in_imm[15:0]};        // bne
      5'd22: w_word = {6'h02, in_imm};                            // j
      5'd23: w_word = {6'h03, in_imm};                            // jal
      default: begin
        w_word    = 32'h0000_0000; // illegal kinds become a nop
        w_illegal = 1'b1;
      end
    endcase
  end

  assign w_rptr_inc        = r_rptr + {{AW{1'b0}}, 1'b1};
  assign w_full            = (r_wptr[AW] != r_rptr[AW]) &&
                             (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_empty           = (r_wptr == r_rptr);
  assign w_at_limit        = (r_accepted >= MAX_W);
  assign w_last_slot       = (r_accepted == (MAX_W - 11'd1));
  // The final descriptor the program may hold is treated as last
  assign w_last            = in_last | w_last_slot;
  assign in_ready          = r_live & ~w_full & (r_state != S_DONE) & ~w_at_limit;
  assign w_push            = in_valid & in_ready;
  assign w_pop             = (r_state == S_WRITE) & im_ack;
  assign w_head            = r_mem[r_rptr[AW-1:0]];
  assign w_empty_after_pop = (w_rptr_inc == r_wptr) & ~w_push;

  // FIFO storage; contents need no reset since the pointers qualify them
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= {w_last, w_word};
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic for the IM write sequencer
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty) w_state_nxt = S_WRITE;
      S_WRITE: begin
        if (im_ack) begin
          if (w_head[32])             w_state_nxt = S_DONE;
          else if (w_empty_after_pop) w_state_nxt = S_IDLE;
        end
      end
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pointers, counters, write address and sticky error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_live     <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_accepted <= '0;
      r_count    <= '0;
      r_addr     <= BASE_ADDR;
      r_err      <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_push) begin
        r_wptr     <= r_wptr + {{AW{1'b0}}, 1'b1};
        r_accepted <= r_accepted + 11'd1;
      end
      if (w_pop) begin
        r_rptr <= w_rptr_inc;
        r_addr <= r_addr + 32'd4;
        if (r_count < MAX_W) r_count <= r_count + 11'd1;
      end
      if ((w_push && w_illegal) || (r_live && in_valid && w_at_limit))
        r_err <= 1'b1;
    end
  end

  assign im_we     = (r_state == S_WRITE);
  assign im_wdata  = im_we ? w_head[31:0] : 32'h0000_0000;
  assign im_addr   = r_addr;
  assign done      = (r_state == S_DONE);
  assign err       = r_err;
  assign count     = r_count;
  assign dbg_state = r_state;

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the pipeline's instruction decoder: turns instruction descriptors (mnemonic kind plus register and immediate fields) into 32-bit MIPS words.
- Writes the words sequentially into instruction memory through a request/acknowledge write port.
- Sits between the program-load / self-test sequencer and the IM.
- Covers the P5 instruction set: add, addu, sub, subu, and, or, slt, sltu, jr, addi, addiu, andi, ori, lui, lw, lh, lb, sw, sh, sb, beq, bne, j, jal.

Parameters:
- DEPTH, 4, entries in the encoded-word FIFO (power of 2, ≥2).
- BASE_ADDR, 32'h0000_3000, IM byte address of the first written word.
- MAX_WORDS, 1024, maximum words accepted per program.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  descriptor valid.
- in_ready  output  1  encoder can accept a descriptor.
- in_kind  input  5  0 add, 1 addu, 2 sub, 3 subu, 4 and, 5 or, 6 slt, 7 sltu, 8 jr, 9 addi, 10 addiu, 11 andi, 12 ori, 13 lui, 14 lw, 15 lh, 16 lb, 17 sw, 18 sh, 19 sb, 20 beq, 21 bne, 22 j, 23 jal; 24–31 illegal.
- in_rs, in_rt, in_rd  input  5 each  register fields.
- in_imm  input  26  imm16 in [15:0]; instr_index in [25:0] for j/jal.
- in_last  input  1  descriptor is the last of the program.
- im_we  output  1  IM write request.
- im_addr  output  32  IM byte address.
- im_wdata  output  32  encoded word.
- im_ack  input  1  IM accepted the write this cycle.
- done  output  1  last word written; sticky.
- err  output  1  illegal kind seen or MAX_WORDS overflow; sticky.
- count  output  11  words written to IM.

Behaviour:
- Reset (reset=0, asynchronous) clears the FIFO and all counters:
  - in_ready=0 while reset is held, 1 in the first cycle after release.
  - im_we=0, im_addr=BASE_ADDR, im_wdata=0.
  - done=0, err=0, count=0, FSM in IDLE.
  - Reset mid-write abandons the pending word; IM side effects are the memory's concern.
- Handshake:
  - A descriptor is accepted when in_valid & in_ready at the clock edge.
  - in_ready = !fifo_full & !done & (accepted < MAX_WORDS).
  - in_ready does not depend on in_valid or on a same-cycle pop. A full FIFO stays not-ready for that cycle even if a pop occurs.
- Encoding (combinational on the input, registered into the FIFO with the last flag):
  - R-type: {6'b0, rs, rt, rd, 5'b0, funct}. funct values: add 20h, addu 21h, sub 22h, subu 23h, and 24h, or 25h, slt 2Ah, sltu 2Bh.
  - jr: {6'b0, rs, 15'b0, 6'h08}.
  - I-type: {op, rs, rt, imm[15:0]}. op values: addi 08h, addiu 09h, andi 0Ch, ori 0Dh, lw 23h, lh 21h, lb 20h, sw 2Bh, sh 29h, sb 28h, beq 04h, bne 05h.
  - lui: {6'h0F, 5'b0, rt, imm[15:0]}.
  - j/jal: {6'h02 / 6'h03, imm[25:0]}.
  - Fields unused by a format are ignored.
  - Illegal kind: the word is 32'h0000_0000 (nop), still written, and err is set.
- Latency: a descriptor accepted at edge k has im_we=1 with its word from cycle k+1 at the earliest. Words are written in acceptance order.
- FSM:
  - IDLE: im_we=0. Goes to WRITE when the FIFO is non-empty.
  - WRITE: im_we=1; im_wdata = FIFO head; im_addr = current address. Address and data stay stable until im_ack. On im_ack:
    - pop the head; address += 4; count += 1;
    - if the popped entry was last → DONE;
    - else stay in WRITE if the FIFO is still non-empty after the pop, else go to IDLE.
  - DONE: im_we=0, done=1, in_ready=0 until reset.
  - im_ack outside WRITE is ignored.
- Overflow:
  - The MAX_WORDS-th accepted descriptor is implicitly marked last.
  - in_valid asserted while in_ready is low because of the MAX_WORDS limit sets err.
  - count saturates at MAX_WORDS.
- Address arithmetic is 32-bit with no wrap check (MAX_WORDS·4 is well within range).

Test Plan:
- addu rs=1 rt=2 rd=3, then ori rs=0 rt=1 imm=1234h with last, im_ack tied 1 → writes 0x00221821 at 0x3000 and 0x34011234 at 0x3004; done=1; count=2.
- lw rs=1 rt=2 imm=4; sw rs=1 rt=2 imm=8; beq rs=1 rt=2 imm=FFFFh; lui rt=5 imm=ABCDh; jal imm=000C00h (last) → 0x8C220004, 0xAC220008, 0x1022FFFF, 0x3C05ABCD, 0x0C000C00 at consecutive addresses.
- im_ack held 0 for 10 cycles while 6 descriptors are offered → in_ready drops after DEPTH(4) accepts; im_addr/im_wdata stable; no loss or reorder after im_ack resumes.
- in_kind=27 → word 0x00000000 written; err=1 and stays 1 through done.
- Assert reset mid-WRITE with 2 words queued → outputs return to reset values immediately (asynchronously); next program starts at 0x3000 with count=0.
- MAX_WORDS=4 override, 5 descriptors offered without last → 4 written; done=1 after the 4th ack; err=1; in_ready=0.
